input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Per-channel synchronizer, debouncer, edge detector with
//                optional auto-repeat, and pulse stretcher for N raw inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int N             = 4,
    parameter int DB_CYCLES     = 4,
    parameter int STRETCH       = 4,
    parameter int EDGE_MODE     = 0,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic [N-1:0] en,
    output logic [N-1:0] level,
    output logic [N-1:0] pulse,
    output logic [N-1:0] stretched,
    output logic         any_pulse
);

    // Debounce counter tops out at DB_CYCLES-1 (the flip happens on that count).
    localparam int C_DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int C_ST_W     = $clog2(STRETCH + 1);
    // Hold counter tops out at one less than the longer of delay and period.
    localparam int C_HOLD_TOP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int C_HOLD_W   = (C_HOLD_TOP > 1) ? $clog2(C_HOLD_TOP) : 1;

    localparam bit   C_REPEAT_EN = (REPEAT_DELAY > 0) && (EDGE_MODE != 2);
    localparam logic C_ACTIVE    = (EDGE_MODE == 1) ? 1'b0 : 1'b1;

    localparam logic [C_DB_W-1:0]   C_DB_LAST     = C_DB_W'(DB_CYCLES - 1);
    localparam logic [C_ST_W-1:0]   C_ST_LOAD     = C_ST_W'(STRETCH);
    localparam logic [C_HOLD_W-1:0] C_DELAY_LAST  = C_HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [C_HOLD_W-1:0] C_PERIOD_LAST = C_HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_SAT    = C_HOLD_W'(C_HOLD_TOP - 1);

    logic [N-1:0]          sync1_q, sync1_d;
    logic [N-1:0]          sync2_q, sync2_d;
    logic [N-1:0]          level_q, level_d;
    logic [N-1:0]          pulse_q, pulse_d;
    logic [N-1:0]          run_q,   run_d;     // repeat timer armed by an edge pulse
    logic [N-1:0]          rep_q,   rep_d;     // first repeat already issued
    logic [C_DB_W-1:0]     db_cnt_q   [N];
    logic [C_DB_W-1:0]     db_cnt_d   [N];
    logic [C_HOLD_W-1:0]   hold_q     [N];
    logic [C_HOLD_W-1:0]   hold_d     [N];
    logic [C_ST_W-1:0]     st_cnt_q   [N];
    logic [C_ST_W-1:0]     st_cnt_d   [N];

    logic                  edge_ok;
    logic                  fire;
    logic [C_HOLD_W-1:0]   hold_last;

    // Next-state for every channel: sync, debounce, edge/repeat, stretch.
    always_comb begin
        sync1_d   = in;
        sync2_d   = sync1_q;
        level_d   = level_q;
        pulse_d   = '0;
        run_d     = '0;
        rep_d     = '0;
        edge_ok   = 1'b0;
        fire      = 1'b0;
        hold_last = '0;
        for (int i = 0; i < N; i++) begin
            db_cnt_d[i] = '0;
            hold_d[i]   = '0;
            st_cnt_d[i] = '0;
            edge_ok     = 1'b0;
            fire        = 1'b0;

            // Count consecutive disagreeing samples; any agreement restarts at 0.
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == C_DB_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end

            if (level_d[i] != level_q[i]) begin
                if (EDGE_MODE == 2) begin
                    edge_ok = 1'b1;
                end else begin
                    edge_ok = (level_d[i] == C_ACTIVE);
                end
            end
            edge_ok = edge_ok & en[i];

            // Repeat timer only runs after a real edge pulse, and stops as soon
            // as the level goes inactive (including the deactivating cycle).
            if (C_REPEAT_EN) begin
                hold_last = rep_q[i] ? C_PERIOD_LAST : C_DELAY_LAST;
                if (edge_ok) begin
                    run_d[i] = 1'b1;
                end else if (run_q[i] && en[i] && (level_d[i] == C_ACTIVE)) begin
                    run_d[i] = 1'b1;
                    rep_d[i] = rep_q[i];
                    if (hold_q[i] == hold_last) begin
                        fire     = 1'b1;
                        rep_d[i] = 1'b1;
                    end else if (hold_q[i] != C_HOLD_SAT) begin
                        hold_d[i] = hold_q[i] + 1'b1;
                    end else begin
                        hold_d[i] = hold_q[i];
                    end
                end
            end

            pulse_d[i] = edge_ok | fire;

            // Retrigger reloads the full length rather than extending it.
            if (pulse_d[i]) begin
                st_cnt_d[i] = C_ST_LOAD;
            end else if (st_cnt_q[i] != '0) begin
                st_cnt_d[i] = st_cnt_q[i] - 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            run_q   <= '0;
            rep_q   <= '0;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= '0;
                hold_q[i]   <= '0;
                st_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            run_q   <= run_d;
            rep_q   <= rep_d;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                hold_q[i]   <= hold_d[i];
                st_cnt_q[i] <= st_cnt_d[i];
            end
        end
    end

    // Outputs are straight from registers; stretched is "count still running".
    always_comb begin
        level     = level_q;
        pulse     = pulse_q;
        any_pulse = |pulse_q;
        stretched = '0;
        for (int i = 0; i < N; i++) begin
            stretched[i] = (st_cnt_q[i] != '0);
        end
    end

endmodule
`default_nettype wire
